// File: rtl/matrix_mult_2x2.sv
// matrix_mult_2x2: sequential signed fixed-point 2x2 matrix multiplier, C = A x B, using one shared multiplier
module matrix_mult_2x2 #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a_0,
  input  logic [W-1:0] a_1,
  input  logic [W-1:0] a_2,
  input  logic [W-1:0] a_3,
  input  logic [W-1:0] b_0,
  input  logic [W-1:0] b_1,
  input  logic [W-1:0] b_2,
  input  logic [W-1:0] b_3,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] c_0,
  output logic [W-1:0] c_1,
  output logic [W-1:0] c_2,
  output logic [W-1:0] c_3,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int AW = 2*W + 1;
  localparam logic signed [AW:0] HALF = (AW+1)'(1) << (FRAC-1);
  localparam logic signed [AW:0] MAXV = {{(AW+2-W){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW+2-W){1'b1}}, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
  state_t                  state_q, state_d;
  logic [3:0][W-1:0]       a_q, b_q, c_q;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [2:0]              k_q;
  logic signed [2*W-1:0]   prod;
  logic signed [AW:0]      rnd, r;
  logic [W-1:0]            sat;
  logic                    accept, mul_en;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? MUL : IDLE;
      MUL:     state_d = &k_q ? OUT : MUL;
      OUT:     state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == OUT;
    accept    = in_ready && in_valid;
    mul_en    = state_q == MUL;
  end
  // k = {output index, term}; output index = {row, col}, term selects A column / B row
  assign prod  = $signed(a_q[{k_q[2], k_q[0]}]) * $signed(b_q[{k_q[0], k_q[1]}]);
  assign acc_d = k_q[0] ? acc_q + AW'(prod) : AW'(prod);
  assign rnd   = (AW+1)'(acc_d) + HALF;
  assign r     = rnd >>> FRAC;
  assign sat   = (r > MAXV) ? MAXV[W-1:0] : (r < MINV) ? MINV[W-1:0] : r[W-1:0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      acc_q <= '0;
      k_q   <= '0;
    end else if (accept) begin
      a_q   <= {a_3, a_2, a_1, a_0};
      b_q   <= {b_3, b_2, b_1, b_0};
      acc_q <= '0;
      k_q   <= '0;
    end else if (mul_en) begin
      acc_q <= acc_d;
      k_q   <= k_q + 3'd1;
      if (k_q[0]) c_q[k_q[2:1]] <= sat;
    end
  end
  assign {c_3, c_2, c_1, c_0} = c_q;
endmodule

// File: tb/tb_matrix_mult_2x2.sv
// tb_matrix_mult_2x2: randomized and directed checks of matrix_mult_2x2 against a plain-arithmetic matrix model
module tb_matrix_mult_2x2;
  logic              clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic              in_ready, out_valid;
  logic [3:0][15:0]  a_x = '0, b_x = '0;
  logic [15:0]       c_0, c_1, c_2, c_3;
  int                n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  matrix_mult_2x2 #(.W(16), .FRAC(8)) dut (
    .clk(clk), .reset(reset),
    .a_0(a_x[0]), .a_1(a_x[1]), .a_2(a_x[2]), .a_3(a_x[3]),
    .b_0(b_x[0]), .b_1(b_x[1]), .b_2(b_x[2]), .b_3(b_x[3]),
    .in_valid(in_valid), .in_ready(in_ready),
    .c_0(c_0), .c_1(c_1), .c_2(c_2), .c_3(c_3),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  function automatic logic [3:0][15:0] model(input logic [3:0][15:0] a, input logic [3:0][15:0] b);
    logic [3:0][15:0] m;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        longint s = 0;
        for (int t = 0; t < 2; t++)
          s += longint'($signed(a[2*i+t])) * longint'($signed(b[2*t+j]));
        s = (s + 128) >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        m[2*i+j] = 16'(s);
      end
    return m;
  endfunction
  task automatic run_op(input logic [3:0][15:0] a, input logic [3:0][15:0] b,
                        output logic [3:0][15:0] c, output int lat);
    @(negedge clk);
    a_x = a; b_x = b; in_valid = 1;
    for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 0;
    a_x = {$urandom, $urandom}; b_x = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
    c = {c_3, c_2, c_1, c_0};
  endtask
  task automatic release_out();
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  task automatic test_reset();
    #1;
    n_chk++;
    if (in_ready !== 1 || out_valid !== 0 || {c_3, c_2, c_1, c_0} !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b c=%h, want 1 0 0", in_ready, out_valid, {c_3, c_2, c_1, c_0});
    end
    repeat (2) @(negedge clk);
    reset = 1;
  endtask
  task automatic test_directed(input string name, input logic [3:0][15:0] a,
                               input logic [3:0][15:0] b, input logic [3:0][15:0] exp);
    logic [3:0][15:0] got;
    int lat;
    run_op(a, b, got, lat);
    n_chk++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want 8", name, lat);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL %s c_%0d: got %h want %h", name, i, got[i], exp[i]);
      end
    end
    release_out();
  endtask
  task automatic test_random();
    logic [3:0][15:0] a, b, got, exp;
    int lat;
    for (int t = 0; t < 30; t++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if (t % 3 == 0) begin
        a = {4{16'($urandom_range(0, 1023)) - 16'd512}};
        b[1] = 16'($urandom_range(0, 511)) - 16'd256;
      end
      exp = model(a, b);
      run_op(a, b, got, lat);
      n_chk++;
      if (got !== exp || lat !== 8) begin
        n_fail++;
        $display("FAIL random #%0d: got %h lat %0d want %h lat 8", t, got, lat, exp);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      release_out();
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0][15:0] a1, b1, a2, b2, got, held;
    int lat;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    run_op(a1, b1, got, lat);
    n_chk++;
    if (got !== model(a1, b1)) begin
      n_fail++;
      $display("FAIL back_to_back first: got %h want %h", got, model(a1, b1));
    end
    held = got;
    a_x = a2; b_x = b2; in_valid = 1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== 1 || in_ready !== 0 || {c_3, c_2, c_1, c_0} !== held) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b c=%h want 1 0 %h",
                 n, out_valid, in_ready, {c_3, c_2, c_1, c_0}, held);
      end
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    n_chk++;
    if (out_valid !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    run_op(a2, b2, got, lat);
    n_chk++;
    if (got !== model(a2, b2) || lat !== 8) begin
      n_fail++;
      $display("FAIL back_to_back second: got %h lat %0d want %h lat 8", got, lat, model(a2, b2));
    end
    release_out();
  endtask
  task automatic test_reset_mid_op();
    logic [3:0][15:0] a, b, exp, got;
    int lat;
    a = {16'h0100, 16'h0200, 16'h0300, 16'h0100}; b = {16'h0040, 16'h0080, 16'h0100, 16'h0200};
    exp = model(a, b);
    @(negedge clk);
    a_x = a; b_x = b; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (c_0 !== exp[0]) begin
      n_fail++;
      $display("FAIL mid_op partial c_0: got %h want %h", c_0, exp[0]);
    end
    reset = 0;
    #1;
    n_chk++;
    if (out_valid !== 0 || in_ready !== 1 || {c_3, c_2, c_1, c_0} !== '0) begin
      n_fail++;
      $display("FAIL mid_op reset: out_valid=%b in_ready=%b c=%h want 0 1 0", out_valid, in_ready, {c_3, c_2, c_1, c_0});
    end
    repeat (12) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== 0) begin
        n_fail++;
        $display("FAIL mid_op held reset: out_valid=%b want 0", out_valid);
      end
    end
    @(negedge clk);
    reset = 1;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    run_op(a, b, got, lat);
    n_chk++;
    if (got !== model(a, b) || lat !== 8) begin
      n_fail++;
      $display("FAIL mid_op after: got %h lat %0d want %h lat 8", got, lat, model(a, b));
    end
    release_out();
  endtask
  initial begin
    test_reset();
    test_directed("identity", {16'h0100, 16'h0000, 16'h0000, 16'h0100},
                  {16'h0200, 16'hFF00, 16'h0056, 16'h1234}, {16'h0200, 16'hFF00, 16'h0056, 16'h1234});
    test_directed("scaling", {16'hFF00, 16'h0000, 16'h0000, 16'h0200},
                  {16'h0080, 16'h0100, 16'h0100, 16'h0080}, {16'hFF80, 16'hFF00, 16'h0200, 16'h0100});
    test_directed("round_pos", {48'h0, 16'h0001}, {48'h0, 16'h0080}, {48'h0, 16'h0001});
    test_directed("round_neg", {48'h0, 16'hFFFF}, {48'h0, 16'h0080}, {48'h0, 16'h0000});
    test_directed("sat_pos", {4{16'h7FFF}}, {4{16'h7FFF}}, {4{16'h7FFF}});
    test_directed("sat_neg", {4{16'h8000}}, {4{16'h7FFF}}, {4{16'h8000}});
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
